// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and widths for the SPI responder (spi_slave) and its helpers.
//   SPI_DATA_W        : bits per SPI frame byte
//   SPI_BIT_CNT_W     : width of the in-byte bit counter
//   spi_slave_state_t : responder state (IDLE = deselected, SHIFT = frame active)
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int SPI_DATA_W    = 8;
   localparam int SPI_BIT_CNT_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_slave_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchronizer for one asynchronous SPI pin, with edge detection
// against a one-cycle-delayed copy of the last synchronizer stage.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   async_in : raw pin from the SPI master
//   level    : synchronized level (last stage)
//   rise     : one-cycle pulse, synchronized 0 -> 1
//   fall     : one-cycle pulse, synchronized 1 -> 0 (only after a real high
//              has been observed since reset)
// Parameters:
//   STAGES    : synchronizer depth (2..3)
//   RESET_VAL : idle level the chain takes during reset
// -----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] syncChain_q;
   logic [STAGES-1:0] fill_q;
   logic              prev_q;
   logic              armed_q;

   // Synchronizer chain plus delayed copy for edge detection. fill_q marks
   // when the last stage holds a genuine pin sample rather than the reset
   // value; a falling edge is only trusted once a real high has been seen,
   // so a pin that is held low across reset never produces a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncChain_q <= {STAGES{RESET_VAL}};
         fill_q      <= '0;
         prev_q      <= RESET_VAL;
         armed_q     <= 1'b0;
      end else begin
         syncChain_q <= {syncChain_q[STAGES-2:0], async_in};
         fill_q      <= {fill_q[STAGES-2:0], 1'b1};
         prev_q      <= syncChain_q[STAGES-1];
         if (fill_q[STAGES-1] && syncChain_q[STAGES-1]) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign level = syncChain_q[STAGES-1];
   assign rise  = syncChain_q[STAGES-1] & ~prev_q;
   assign fall  = ~syncChain_q[STAGES-1] & prev_q & armed_q;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, with
// multi-byte bursts while cs_n stays low. sclk/cs_n/mosi are oversampled on
// clk; sclk is never used as a clock.
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   sclk, cs_n, mosi    : SPI pins from the master
//   miso                : SPI data to the master
//   tx_data/tx_valid    : byte offered for a coming frame byte
//   tx_ready            : one-entry holding register is empty
//   rx_data/rx_valid    : last received byte / one-cycle update pulse
//   busy                : synchronized cs_n low
//   frame_err           : one-cycle pulse, cs_n rose mid-byte
// Parameters:
//   SYNC_STAGES : synchronizer depth (2..3)
//   DEFAULT_TX  : byte sent when nothing is queued at a byte boundary
// Build option:
//   SPI_SLAVE_MISO_OE_EN : adds miso_oe (= busy) for a pad tristate; miso then
//                          keeps its last value when deselected. Without it,
//                          miso is forced low whenever busy is low.
// -----------------------------------------------------------------------------
module spi_slave
   import spi_pkg::*;
#(
   parameter int                    SYNC_STAGES = 2,
   parameter logic [SPI_DATA_W-1:0] DEFAULT_TX  = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [SPI_DATA_W-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [SPI_DATA_W-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  frame_err
`ifdef SPI_SLAVE_MISO_OE_EN
   ,
   output logic                  miso_oe
`endif
);

   logic sclkRise, sclkFall, csRise, csFall;
   logic sclkLevelUnused, csLevelUnused;
   logic mosiLevel;

   logic [SYNC_STAGES-1:0]   mosiSync_q;

   spi_slave_state_t         state_q;
   logic [SPI_BIT_CNT_W-1:0] bitCnt_q;
   logic [SPI_DATA_W-1:0]    txShift_q;
   logic [SPI_DATA_W-2:0]    rxShift_q;
   logic [SPI_DATA_W-1:0]    hold_q;
   logic                     holdFull_q;
   logic                     miso_q;
   logic [SPI_DATA_W-1:0]    rxData_q;
   logic                     rxValid_q;
   logic                     busy_q;
   logic                     frameErr_q;

   logic [SPI_DATA_W-1:0]    reloadByte_d;
   logic                     byteDone;
   logic                     reloadNow;
   logic                     txAccept;

   spi_sync_edge #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b0)
   ) u_sclkSync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (sclk),
      .level    (sclkLevelUnused),
      .rise     (sclkRise),
      .fall     (sclkFall)
   );

   spi_sync_edge #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_csSync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (cs_n),
      .level    (csLevelUnused),
      .rise     (csRise),
      .fall     (csFall)
   );

   // mosi only needs its level; its chain depth matches sclk so the data bit
   // and the rising edge that samples it arrive together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosiSync_q <= '0;
      end else begin
         mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
      end
   end

   assign mosiLevel = mosiSync_q[SYNC_STAGES-1];

   // Byte-boundary bookkeeping. A reload happens at frame start and after the
   // eighth rising sclk edge of every byte; cs_rise suppresses the sclk path.
   always_comb begin
      reloadByte_d = holdFull_q ? hold_q : DEFAULT_TX;
      byteDone     = (state_q == SHIFT) && !csRise && sclkRise && (bitCnt_q == '1);
      reloadNow    = ((state_q == IDLE) && csFall) || byteDone;
      txAccept     = tx_valid && !holdFull_q;
   end

   // One-entry holding register. An accept can only happen while empty, so an
   // accept coinciding with a reload means the reload took DEFAULT_TX and the
   // new byte waits for the next boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q     <= '0;
         holdFull_q <= 1'b0;
      end else if (txAccept) begin
         hold_q     <= tx_data;
         holdFull_q <= 1'b1;
      end else if (reloadNow) begin
         holdFull_q <= 1'b0;
      end
   end

   // Frame state machine. Rising sclk samples mosi; falling sclk advances
   // miso, except at a byte boundary where miso presents the MSB of the byte
   // reloaded on the preceding rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bitCnt_q   <= '0;
         txShift_q  <= '0;
         rxShift_q  <= '0;
         miso_q     <= 1'b0;
         rxData_q   <= '0;
         rxValid_q  <= 1'b0;
         busy_q     <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         rxValid_q  <= 1'b0;
         frameErr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (csFall) begin
                  state_q   <= SHIFT;
                  txShift_q <= reloadByte_d;
                  miso_q    <= reloadByte_d[SPI_DATA_W-1];
                  bitCnt_q  <= '0;
                  busy_q    <= 1'b1;
               end
            end
            SHIFT: begin
               if (csRise) begin
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
                  frameErr_q <= (bitCnt_q != '0);
`ifndef SPI_SLAVE_MISO_OE_EN
                  miso_q     <= 1'b0;
`endif
               end else begin
                  if (sclkRise) begin
                     rxShift_q <= {rxShift_q[SPI_DATA_W-3:0], mosiLevel};
                     bitCnt_q  <= bitCnt_q + 1'b1;
                     if (bitCnt_q == '1) begin
                        rxData_q  <= {rxShift_q, mosiLevel};
                        rxValid_q <= 1'b1;
                        txShift_q <= reloadByte_d;
                     end
                  end
                  if (sclkFall) begin
                     if (bitCnt_q != '0) begin
                        txShift_q <= {txShift_q[SPI_DATA_W-2:0], 1'b0};
                        miso_q    <= txShift_q[SPI_DATA_W-2];
                     end else begin
                        miso_q    <= txShift_q[SPI_DATA_W-1];
                     end
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tx_ready  = !holdFull_q;
   assign rx_data   = rxData_q;
   assign rx_valid  = rxValid_q;
   assign busy      = busy_q;
   assign frame_err = frameErr_q;

`ifdef SPI_SLAVE_MISO_OE_EN
   assign miso    = miso_q;
   assign miso_oe = busy_q;
`else
   assign miso    = miso_q & busy_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Bench for spi_slave. Two instances: dut0 with SYNC_STAGES=2 and dut1 with
// SYNC_STAGES=3, each on its own SPI bus. The bench plays the SPI master and
// the local transmit side; expected bytes come from a queue model of what
// the responder should send (bytes accepted in order, DEFAULT_TX when none
// is pending at a byte start) and of what the master shifted in.
// -----------------------------------------------------------------------------
module tb_spi_slave;

   localparam logic [7:0] DEF_TX = 8'h00;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      sclkV, csV, mosiV, txValidV;
   logic [1:0][7:0] txDataV;
   wire  [1:0]      misoV, txReadyV, rxValidV, busyV, frameErrV;
   wire  [1:0][7:0] rxDataV;

   int              checks;
   int              errors;
   logic [8:0]      rxExpQ[$];
   logic [8:0]      misoExpQ[$];
   logic [8:0]      misoObsQ[$];
   logic [7:0]      txQ0[$];
   logic [7:0]      txQ1[$];
   logic [7:0]      mBytes[4];
   logic [7:0]      lastRx[2];
   int              feCount[2];
   logic [7:0]      loopVals[3] = '{8'h00, 8'hFF, 8'h55};

   // Free-running system clock.
   always #5 clk = ~clk;

   spi_slave #(.SYNC_STAGES(2), .DEFAULT_TX(DEF_TX)) dut0 (
      .clk(clk), .rst_n(rst_n), .sclk(sclkV[0]), .cs_n(csV[0]), .mosi(mosiV[0]),
      .miso(misoV[0]), .tx_data(txDataV[0]), .tx_valid(txValidV[0]),
      .tx_ready(txReadyV[0]), .rx_data(rxDataV[0]), .rx_valid(rxValidV[0]),
      .busy(busyV[0]), .frame_err(frameErrV[0])
   );

   spi_slave #(.SYNC_STAGES(3), .DEFAULT_TX(DEF_TX)) dut1 (
      .clk(clk), .rst_n(rst_n), .sclk(sclkV[1]), .cs_n(csV[1]), .mosi(mosiV[1]),
      .miso(misoV[1]), .tx_data(txDataV[1]), .tx_valid(txValidV[1]),
      .tx_ready(txReadyV[1]), .rx_data(rxDataV[1]), .rx_valid(rxValidV[1]),
      .busy(busyV[1]), .frame_err(frameErrV[1])
   );

   function automatic int stagesOf(input int idx);
      return (idx == 0) ? 2 : 3;
   endfunction

   // Next byte the responder should send: oldest accepted byte, else default.
   function automatic logic [7:0] popTx(input int idx);
      logic [7:0] b;
      b = DEF_TX;
      if (idx == 0) begin
         if (txQ0.size() > 0) b = txQ0.pop_front();
      end else if (txQ1.size() > 0) begin
         b = txQ1.pop_front();
      end
      return b;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Offer a byte on the local transmit side and wait (bounded) for accept.
   task automatic pushTx(input int idx, input logic [7:0] v);
      int waited;
      waited = 0;
      txDataV[idx]  = v;
      txValidV[idx] = 1'b1;
      while (!txReadyV[idx] && waited < 2000) begin
         tick(1);
         waited++;
      end
      checkOutput("tx_accept_timeout", (waited >= 2000) ? 1 : 0, 0);
      if (waited < 2000) begin
         tick(1);
         if (idx == 0) txQ0.push_back(v);
         else          txQ1.push_back(v);
      end
      txValidV[idx] = 1'b0;
   endtask

   // Master side of one frame: nBytes from mBytes, mode 0, phases of 'half'
   // clk cycles. abortRises > 0 raises cs_n after that many rising edges.
   task automatic applyStimulus(input int idx, input int half, input int nBytes, input int abortRises);
      logic [7:0] expTx, obs, mb, nb;
      int         rises, fe0;
      bit         stop;
      rises = 0;
      stop  = 1'b0;
      fe0   = feCount[idx];
      mb    = mBytes[0];
      csV[idx]   = 1'b0;
      expTx      = popTx(idx);
      mosiV[idx] = mb[7];
      tick(half);
      checkOutput("busy_in_frame", busyV[idx], 1);
      for (int b = 0; b < nBytes && !stop; b++) begin
         mb  = mBytes[b];
         obs = '0;
         for (int k = 7; k >= 0 && !stop; k--) begin
            obs = {obs[6:0], misoV[idx]};
            sclkV[idx] = 1'b1;
            rises++;
            if (k == 0) begin
               rxExpQ.push_back({idx[0], mb});
               misoExpQ.push_back({idx[0], expTx});
               misoObsQ.push_back({idx[0], obs});
               expTx = popTx(idx);
            end
            tick(half);
            sclkV[idx] = 1'b0;
            if (k > 0) begin
               mosiV[idx] = mb[k-1];
            end else if (b + 1 < nBytes) begin
               nb = mBytes[b+1];
               mosiV[idx] = nb[7];
            end
            tick(half);
            if (rises == abortRises) stop = 1'b1;
         end
      end
      csV[idx] = 1'b1;
      tick(stagesOf(idx) + 4);
      checkOutput("busy_after_frame", busyV[idx], 0);
      checkOutput("frame_err_pulses", feCount[idx] - fe0, (abortRises > 0) ? 1 : 0);
   endtask

   // Scoreboard monitor: pops expectations whenever a DUT presents a byte.
   task automatic monitorLoop();
      logic [8:0] exp, got, mexp, mobs;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
               if (rxValidV[i]) begin
                  checks++;
                  got = {i[0], rxDataV[i]};
                  if (rxExpQ.size() == 0) begin
                     errors++;
                     $display("[TB] FAIL rx_unexpected dut%0d: got %h, required no rx_valid", i, rxDataV[i]);
                  end else begin
                     exp = rxExpQ.pop_front();
                     if (got !== exp) begin
                        errors++;
                        $display("[TB] FAIL rx_byte: got %h, required %h", got, exp);
                     end
                     lastRx[i] = exp[7:0];
                  end
               end
               if (frameErrV[i]) feCount[i]++;
            end
         end
         while (misoExpQ.size() > 0 && misoObsQ.size() > 0) begin
            mexp = misoExpQ.pop_front();
            mobs = misoObsQ.pop_front();
            checks++;
            if (mobs !== mexp) begin
               errors++;
               $display("[TB] FAIL miso_byte: got %h, required %h", mobs, mexp);
            end
         end
      end
   endtask

   // Hard stop in case anything above stalls.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence: reset, directed scenarios, minimum timing, random frames.
   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      sclkV = '0; csV = '1; mosiV = '0; txValidV = '0; txDataV = '0;
      lastRx[0] = '0; lastRx[1] = '0;
      feCount[0] = 0; feCount[1] = 0;
      fork
         monitorLoop();
      join_none
      tick(4);
      checkOutput("reset_miso", misoV[0], 0);
      checkOutput("reset_rx_data", rxDataV[0], 8'h00);
      checkOutput("reset_rx_valid", rxValidV[0], 0);
      checkOutput("reset_busy", busyV[0], 0);
      checkOutput("reset_frame_err", frameErrV[0], 0);
      checkOutput("reset_tx_ready", txReadyV[0], 1);
      rst_n = 1'b1;
      tick(6);

      $display("[TB] single byte");
      pushTx(0, 8'hA5);
      mBytes[0] = 8'h3C;
      applyStimulus(0, 6, 1, 0);
      checkOutput("rx_data_single", rxDataV[0], 8'h3C);

      $display("[TB] three-byte burst");
      pushTx(0, 8'h11);
      mBytes[0] = 8'h01; mBytes[1] = 8'h02; mBytes[2] = 8'h03;
      fork
         applyStimulus(0, 6, 3, 0);
         begin
            tick(6 + 5 * 12);
            pushTx(0, 8'h22);
         end
      join
      checkOutput("rx_data_burst", rxDataV[0], 8'h03);

      $display("[TB] aborted byte");
      mBytes[0] = 8'($urandom);
      applyStimulus(0, 6, 1, 5);
      checkOutput("rx_data_held", rxDataV[0], lastRx[0]);

      $display("[TB] holding register handshake");
      pushTx(0, 8'h5A);
      mBytes[0] = 8'($urandom);
      fork
         applyStimulus(0, 6, 1, 0);
         begin
            tick(6 + 2 * 12);
            pushTx(0, 8'h66);
            pushTx(0, 8'h7E);
         end
         begin
            tick(6 + 5 * 12);
            checkOutput("tx_ready_while_full", txReadyV[0], 0);
         end
      join
      mBytes[0] = 8'($urandom);
      applyStimulus(0, 6, 1, 0);

      $display("[TB] reset mid-byte");
      csV[0] = 1'b0;
      mosiV[0] = 1'b1;
      tick(6);
      for (int n = 0; n < 3; n++) begin
         sclkV[0] = 1'b1; tick(6);
         sclkV[0] = 1'b0; tick(6);
      end
      rst_n = 1'b0;
      tick(2);
      checkOutput("midreset_miso", misoV[0], 0);
      checkOutput("midreset_rx_data", rxDataV[0], 8'h00);
      checkOutput("midreset_rx_valid", rxValidV[0], 0);
      checkOutput("midreset_busy", busyV[0], 0);
      checkOutput("midreset_frame_err", frameErrV[0], 0);
      checkOutput("midreset_tx_ready", txReadyV[0], 1);
      lastRx[0] = '0; lastRx[1] = '0;
      txQ0.delete(); txQ1.delete();
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         sclkV[0] = 1'b1; tick(6);
         sclkV[0] = 1'b0; tick(6);
      end
      checkOutput("busy_after_reset_cs_low", busyV[0], 0);
      checkOutput("rx_data_after_reset", rxDataV[0], 8'h00);
      csV[0] = 1'b1;
      tick(8);
      mBytes[0] = 8'hC3;
      applyStimulus(0, 6, 1, 0);
      checkOutput("rx_data_after_reset_frame", rxDataV[0], 8'hC3);

      $display("[TB] minimum sclk phases");
      for (int v = 0; v < 3; v++) begin
         for (int d = 0; d < 2; d++) begin
            pushTx(d, loopVals[v]);
            mBytes[0] = loopVals[v];
            applyStimulus(d, stagesOf(d) + 3, 1, 0);
            checkOutput("loopback_rx", rxDataV[d], loopVals[v]);
         end
      end

      $display("[TB] random frames");
      for (int r = 0; r < 8; r++) begin
         int nB, half;
         nB   = $urandom_range(3, 1);
         half = $urandom_range(9, 5);
         for (int b = 0; b < 4; b++) mBytes[b] = 8'($urandom);
         if ($urandom_range(1, 0) == 1) pushTx(0, 8'($urandom));
         applyStimulus(0, half, nB, 0);
      end

      tick(30);
      checkOutput("rx_scoreboard_drained", rxExpQ.size(), 0);
      checkOutput("miso_scoreboard_drained", misoExpQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave), mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames; multi-byte transfers while cs_n stays low.
- Sits on the device side of our SPI master link. Oversamples sclk/cs_n/mosi on system clock clk; sclk is never used as a clock.
- Presents received bytes and accepts transmit bytes via valid/ready-style handshakes to local logic.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer for sclk, cs_n, mosi (legal 2..3).
- DEFAULT_TX, 8'h00, byte shifted out when no transmit byte is queued at a byte boundary.

Ports:
- clk  input  1  system clock
- rst_n  input  1  async active-low reset
- sclk  input  1  SPI clock from master, idle low
- cs_n  input  1  chip select, active low
- mosi  input  1  master out, slave in
- miso  output  1  slave out, master in
- tx_data  input  8  byte to send in next frame
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  holding register empty; transfer on tx_valid && tx_ready
- rx_data  output  8  last received byte, held until next byte completes
- rx_valid  output  1  one-cycle pulse, rx_data updated
- busy  output  1  synchronized cs_n low (frame active)
- frame_err  output  1  one-cycle pulse: cs_n rose with 1..7 bits of a byte received

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. Reset values: miso=0, rx_data=8'h00, rx_valid=0, busy=0, frame_err=0, tx_ready=1. Sync chains reset to sclk=0, cs_n=1, mosi=0.
- Edge detection runs on the last sync stage against a one-cycle-delayed copy: sclk_rise, sclk_fall, cs_fall, cs_rise.
- Timing requirement on the master: sclk high and low phases are each >= SYNC_STAGES+3 clk cycles. Behaviour outside this limit is undefined.
- Holding register: 1 entry. tx_ready = !hold_full. Accept on tx_valid && tx_ready. Cleared when it is loaded into the shifter.
- States: IDLE and SHIFT.
- IDLE -> SHIFT on cs_fall:
  - Load the shifter from the holding register if full, else from DEFAULT_TX.
  - Drive miso = shifter[7] in the same cycle.
  - Set bit_cnt=0, busy=1.
- SHIFT, on sclk_rise:
  - rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++.
  - When bit_cnt was 7: rx_data <= {rx_shift[6:0], mosi_sync}, rx_valid=1 next cycle, bit_cnt wraps to 0, and the shifter reloads from the holding register (or DEFAULT_TX).
- SHIFT, on sclk_fall:
  - If not at a byte boundary, shift the tx shifter left and miso = next bit.
  - At a byte boundary, miso = MSB of the reloaded byte.
- SHIFT -> IDLE on cs_rise:
  - busy=0, miso=0.
  - frame_err pulses if bit_cnt != 0. The partial byte is discarded; rx_data is unchanged.
- Simultaneous events:
  - Holding-register accept and reload in the same cycle: the reload takes the old content (or DEFAULT_TX if empty), and the new byte is held for the next boundary.
  - cs_rise has priority over sclk edges in the same cycle.
- rx_valid has no backpressure. Local logic must consume rx_data within 8 sclk periods.
- Asynchronous reset mid-frame: all state returns to reset values. Sync chains see cs_n high, so no spurious cs_fall. If cs_n is still low after reset, a cs_fall is detected only after cs_n goes high and low again.

Optional Feature:
- SPI_SLAVE_MISO_OE_EN:
  - Defined: adds output miso_oe (1 bit) = busy, reset 0, for a pad tristate. miso holds its last value when deselected.
  - Undefined: no miso_oe port; miso forced to 0 whenever busy=0.

Decomposition:
- Package spi_pkg:
  - spi_slave_state_t enum {IDLE, SHIFT}.
  - SPI_DATA_W=8.
  - SPI_BIT_CNT_W=3.
- Sub-module spi_sync_edge (parameter STAGES; in async_in; out level, rise, fall), instantiated for sclk and cs_n. mosi uses the level only.

Test Plan:
- Single byte: tx queued 8'hA5, master sends 8'h3C → master receives 8'hA5; rx_data=8'h3C with one rx_valid pulse; busy falls after cs_n high; frame_err=0.
- Three-byte burst, tx queued 8'h11 then 8'h22 just before the first boundary, none for the third; master sends 8'h01, 8'h02, 8'h03 → master gets 8'h11, 8'h22, DEFAULT_TX 8'h00; three rx_valid pulses with 8'h01, 8'h02, 8'h03.
- cs_n raised after 5 rising sclk edges → frame_err one pulse; rx_data keeps its previous value; no rx_valid.
- Holding-register handshake: tx_valid held with 8'h7E while the register is full → tx_ready=0 until the boundary reload, then accepts in 1 cycle; 8'h7E appears in the following frame.
- rst_n asserted mid-byte with cs_n low, released, then a new frame sending 8'hC3 → all outputs at reset values; no activity until a fresh cs_n fall; then rx_data=8'hC3.
- Minimum timing: sclk phases of exactly SYNC_STAGES+3 clk with both SYNC_STAGES=2 and 3 → error-free loopback of 8'h00, 8'hFF, 8'h55.
